// File: rtl/fm_operator_pair.sv
// Two-operator FM voice: a modulator sine offsets the carrier phase, one offset-binary
// sample per divided sample tick, produced by a fixed 4-cycle lookup pipeline.
module fm_operator_pair #(
    parameter int unsigned CLK_DIV   = 259,
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned SAMPLE_W  = 8,
    parameter int unsigned LUT_AW    = 8,
    parameter int unsigned DEPTH_W   = 8,
    parameter int unsigned MOD_SHIFT = 0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic [PHASE_W-1:0]  car_freq_i,
    input  logic [PHASE_W-1:0]  mod_freq_i,
    input  logic [DEPTH_W-1:0]  depth_i,
    output logic                sample_val_o,
    output logic [SAMPLE_W-1:0] sample_data_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned LUT_N = 2 ** LUT_AW;
    localparam int unsigned P_W   = SAMPLE_W + DEPTH_W + 1;
    localparam int unsigned ADR_SH = PHASE_W - LUT_AW;
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // round(A*sin(2*pi*k/N)) in 2^30 fixed point via quarter-wave symmetry and Taylor series
    function automatic longint sine_val(input int unsigned k);
        longint kk, n, quarter, quad, r, q, x, x2, term, sum, amp, mag;
        kk      = longint'(k);
        n       = longint'(LUT_N);
        quarter = n / 4;
        quad    = kk / quarter;
        r       = kk % quarter;
        q       = (quad == 1 || quad == 3) ? quarter - r : r;
        x       = (64'sd3373259426 * 2 * q) / n;
        x2      = (x * x) >>> 30;
        term    = x;
        sum     = x;
        for (int i = 1; i <= 6; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) << (SAMPLE_W - 1)) - 1;
        mag = (amp * sum + (longint'(1) << 29)) >>> 30;
        return (quad >= 2) ? -mag : mag;
    endfunction

    logic signed [SAMPLE_W-1:0] lut [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam logic signed [SAMPLE_W-1:0] V = SAMPLE_W'(sine_val(k));
        assign lut[k] = V;
    end

    typedef enum logic [2:0] {IDLE, MOD_RD, SCALE, CAR_RD, OUT} state_t;

    state_t                     state_q;
    logic [DIV_W-1:0]           div_q;
    logic [PHASE_W-1:0]         car_phase_q;
    logic [PHASE_W-1:0]         mod_phase_q;
    logic [PHASE_W-1:0]         car_freq_q;
    logic [PHASE_W-1:0]         mod_freq_q;
    logic [DEPTH_W-1:0]         depth_q;
    logic signed [SAMPLE_W-1:0] m_q;
    logic [PHASE_W-1:0]         offset_q;
    logic                       tick_c;
    logic signed [P_W-1:0]      prod_c;
    logic [LUT_AW-1:0]          mod_addr_c;
    logic [LUT_AW-1:0]          car_addr_c;

    assign tick_c     = (div_q == DIV_W'(CLK_DIV));
    assign prod_c     = P_W'(m_q) * P_W'($signed({1'b0, depth_q}));
    assign mod_addr_c = LUT_AW'(mod_phase_q >> ADR_SH);
    assign car_addr_c = LUT_AW'((car_phase_q + offset_q) >> ADR_SH);

    // Divider, shadow capture and the IDLE->MOD_RD->SCALE->CAR_RD->OUT pipeline
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= IDLE;
            div_q         <= '0;
            car_phase_q   <= '0;
            mod_phase_q   <= '0;
            car_freq_q    <= '0;
            mod_freq_q    <= '0;
            depth_q       <= '0;
            m_q           <= '0;
            offset_q      <= '0;
            sample_val_o  <= 1'b0;
            sample_data_o <= MID;
        end else begin
            div_q        <= tick_c ? '0 : div_q + DIV_W'(1);
            sample_val_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_c) begin
                        state_q <= MOD_RD;
                        if (en_i) begin
                            car_freq_q <= car_freq_i;
                            mod_freq_q <= mod_freq_i;
                            depth_q    <= depth_i;
                        end else begin
                            car_freq_q  <= '0;
                            mod_freq_q  <= '0;
                            depth_q     <= '0;
                            car_phase_q <= '0;
                            mod_phase_q <= '0;
                        end
                    end
                end
                MOD_RD: begin
                    m_q     <= lut[mod_addr_c];
                    state_q <= SCALE;
                end
                SCALE: begin
                    offset_q <= PHASE_W'(prod_c) <<< MOD_SHIFT;
                    state_q  <= CAR_RD;
                end
                CAR_RD: begin
                    sample_data_o <= lut[car_addr_c] + MID;
                    sample_val_o  <= 1'b1;
                    state_q       <= OUT;
                end
                OUT: begin
                    car_phase_q <= car_phase_q + car_freq_q;
                    mod_phase_q <= mod_phase_q + mod_freq_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
